// File: rtl/count_pkg.sv
// Shared encodings for the BCD counter sequencing logic.
// Speed codes double as the display digit value, so they must stay 0/1/2.
package count_pkg;

  localparam logic [1:0] SPD_SLOW   = 2'b00;
  localparam logic [1:0] SPD_NORMAL = 2'b01;
  localparam logic [1:0] SPD_FAST   = 2'b10;

  localparam logic [1:0] ST_PAUSE = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_LIMIT = 2'd2;

  // Saturating speed update; simultaneous up/down requests cancel.
  function automatic logic [1:0] speed_next(input logic [1:0] cur,
                                            input logic       up,
                                            input logic       dn);
    logic [1:0] nxt;
    nxt = cur;
    if (up && !dn) begin
      if (cur == SPD_SLOW)        nxt = SPD_NORMAL;
      else if (cur == SPD_NORMAL) nxt = SPD_FAST;
    end else if (dn && !up) begin
      if (cur == SPD_FAST)        nxt = SPD_NORMAL;
      else if (cur == SPD_NORMAL) nxt = SPD_SLOW;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Programmable step-rate prescaler: one counter whose period is selected by
// the speed code (4B / 2B / B clk cycles). tick is high for the single cycle
// in which the counter sits at period-1 while enabled; the counter then wraps.
module step_prescaler
  import count_pkg::*;
#(
  parameter int unsigned BASE_TICKS = 8388608,
  parameter int unsigned CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [CNT_W-1:0] FAST_M1   = CNT_W'(BASE_TICKS - 1);
  localparam logic [CNT_W-1:0] NORMAL_M1 = CNT_W'(2 * BASE_TICKS - 1);
  localparam logic [CNT_W-1:0] SLOW_M1   = CNT_W'(4 * BASE_TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_m1;

  // Terminal count for the selected speed; unused code 2'b11 falls back to SLOW.
  always_comb begin
    period_m1 = SLOW_M1;
    case (speed)
      SPD_FAST:   period_m1 = FAST_M1;
      SPD_NORMAL: period_m1 = NORMAL_M1;
      default:    period_m1 = SLOW_M1;
    endcase
  end

  // A clear wins over a coincident terminal count so no tick escapes a speed change.
  always_comb begin
    tick  = enable && !clear && (cnt_q == period_m1);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register; holds whenever disabled so a paused period resumes.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/count_step_scheduler.sv
// Sequencing controller for the 2-digit BCD up/down counter: run/pause FSM,
// 3-level speed select and step-rate prescaler. Emits registered one-cycle
// step strobes qualified by step_up; stops at 00/99 via at_min/at_max.
// Optional build macro COUNT_STEP_AUTO_REVERSE_EN: ping-pong mode where a
// tick at a limit reverses direction and steps instead of entering LIMIT.
module count_step_scheduler
  import count_pkg::*;
#(
  parameter int unsigned BASE_TICKS = 8388608,
  parameter int unsigned CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_pulse,
  input  logic       speed_up_pulse,
  input  logic       speed_down_pulse,
  input  logic       dir_level,
  input  logic       at_max,
  input  logic       at_min,
  output logic       step,
  output logic       step_up,
  output logic       running,
  output logic       limit_hit,
  output logic [1:0] speed
);

  logic [1:0] state_q, state_d;
  logic [1:0] speed_q, speed_d;
  logic       dir_q, dir_d;
  logic       step_q, step_d;
  logic       step_up_q, step_up_d;
  logic       running_q, running_d;
  logic       limit_hit_q, limit_hit_d;
  logic       limit_pulse;
  logic       speed_chg;
  logic       presc_en, presc_clr, tick;
  logic       blocked;
`ifdef COUNT_STEP_AUTO_REVERSE_EN
  logic       dir_level_q;
`endif

  // Speed request handling; any effective change restarts the period.
  always_comb begin
    speed_d   = speed_next(speed_q, speed_up_pulse, speed_down_pulse);
    speed_chg = (speed_d != speed_q);
  end

  // The prescaler advances only in RUN; en_pulse freezes it so a pause on the
  // terminal cycle keeps the count at period-1 and the step fires on resume.
  always_comb begin
    presc_en  = (state_q == ST_RUN) && !en_pulse;
    presc_clr = speed_chg || (state_q == ST_LIMIT);
    blocked   = dir_q ? at_max : at_min;
  end

  step_prescaler #(
    .BASE_TICKS (BASE_TICKS),
    .CNT_W      (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (presc_en),
    .clear  (presc_clr),
    .speed  (speed_q),
    .tick   (tick)
  );

  // Mode FSM, step generation and direction tracking.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    step_up_d   = step_up_q;
    limit_pulse = 1'b0;

`ifndef COUNT_STEP_AUTO_REVERSE_EN
    if (state_q != ST_PAUSE) dir_d = ~dir_level;
`endif

    case (state_q)
      ST_PAUSE: begin
        if (en_pulse) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (en_pulse) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          if (blocked) begin
`ifdef COUNT_STEP_AUTO_REVERSE_EN
            dir_d       = ~dir_q;
            step_d      = 1'b1;
            step_up_d   = ~dir_q;
            limit_pulse = 1'b1;
`else
            state_d = ST_LIMIT;
`endif
          end else begin
            step_d    = 1'b1;
            step_up_d = dir_q;
          end
        end
      end
      ST_LIMIT: begin
        if (en_pulse)      state_d = ST_PAUSE;
        else if (!blocked) state_d = ST_RUN;
      end
      default: state_d = ST_PAUSE;
    endcase

`ifdef COUNT_STEP_AUTO_REVERSE_EN
    // A switch edge overrides an automatic reversal in the same cycle.
    if ((state_q == ST_RUN) && (dir_level != dir_level_q)) dir_d = ~dir_level;
`endif

    running_d = (state_d != ST_PAUSE);
`ifdef COUNT_STEP_AUTO_REVERSE_EN
    limit_hit_d = limit_pulse;
`else
    limit_hit_d = (state_d == ST_LIMIT);
`endif
  end

  // Registered state and outputs; reset drops any pending step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PAUSE;
      speed_q     <= SPD_SLOW;
      dir_q       <= 1'b1;
      step_q      <= 1'b0;
      step_up_q   <= 1'b1;
      running_q   <= 1'b0;
      limit_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      step_up_q   <= step_up_d;
      running_q   <= running_d;
      limit_hit_q <= limit_hit_d;
    end
  end

`ifdef COUNT_STEP_AUTO_REVERSE_EN
  // Previous switch level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) dir_level_q <= 1'b0;
    else     dir_level_q <= dir_level;
  end
`endif

  assign step      = step_q;
  assign step_up   = step_up_q;
  assign running   = running_q;
  assign limit_hit = limit_hit_q;
  assign speed     = speed_q;

endmodule

// File: tb/tb_count_step_scheduler.sv
// Scoreboard bench for count_step_scheduler with BASE_TICKS = 4.
module tb_count_step_scheduler;

  localparam int unsigned TB_BASE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_pulse = 1'b0;
  logic       speed_up_pulse = 1'b0;
  logic       speed_down_pulse = 1'b0;
  logic       dir_level = 1'b0;
  logic       at_max = 1'b0;
  logic       at_min = 1'b0;
  logic       step, step_up, running, limit_hit;
  logic [1:0] speed;

  count_step_scheduler #(
    .BASE_TICKS (TB_BASE),
    .CNT_W      (5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en_pulse         (en_pulse),
    .speed_up_pulse   (speed_up_pulse),
    .speed_down_pulse (speed_down_pulse),
    .dir_level        (dir_level),
    .at_max           (at_max),
    .at_min           (at_min),
    .step             (step),
    .step_up          (step_up),
    .running          (running),
    .limit_hit        (limit_hit),
    .speed            (speed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       step;
    logic       step_up;
    logic       running;
    logic       limit_hit;
    logic [1:0] speed;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: abstract mode, speed level, elapsed cycles in period.
  typedef enum int {M_PAUSED, M_RUNNING, M_STOPPED} mmode_t;
  mmode_t      m_mode = M_PAUSED;
  int unsigned m_spd = 0;
  int unsigned m_el = 0;
  bit          m_up = 1'b1;
  bit          m_step = 1'b0;
  bit          m_step_up = 1'b1;
  bit          m_pulse = 1'b0;
  bit          m_prev_lvl = 1'b0;

  function automatic int unsigned m_period();
    return TB_BASE << (2 - m_spd);
  endfunction

  task automatic model_edge(input bit r, e, u, d, dl, mx, mn, output exp_t x);
    int unsigned per, nsp;
    bit chg, counting, tk, blocked;
    per = m_period();
    if (r) begin
      m_mode = M_PAUSED; m_spd = 0; m_el = 0; m_up = 1'b1;
      m_step = 1'b0; m_step_up = 1'b1; m_pulse = 1'b0; m_prev_lvl = 1'b0;
    end else begin
      nsp = m_spd;
      if (u && !d && m_spd < 2) nsp = m_spd + 1;
      else if (d && !u && m_spd > 0) nsp = m_spd - 1;
      chg      = (nsp != m_spd);
      counting = (m_mode == M_RUNNING) && !e;
      tk       = counting && !chg && (m_el == per - 1);
      blocked  = m_up ? mx : mn;
      m_step   = 1'b0;
      m_pulse  = 1'b0;
      if (chg || m_mode == M_STOPPED) m_el = 0;
      else if (counting) m_el = (m_el + 1) % per;
      case (m_mode)
        M_PAUSED: if (e) m_mode = M_RUNNING;
        M_RUNNING: begin
`ifndef COUNT_STEP_AUTO_REVERSE_EN
          if (e) m_mode = M_PAUSED;
          else if (tk && blocked) m_mode = M_STOPPED;
          else if (tk) begin m_step = 1'b1; m_step_up = m_up; end
          m_up = !dl;
`else
          if (e) m_mode = M_PAUSED;
          else if (tk && blocked) begin
            m_step = 1'b1; m_step_up = !m_up; m_pulse = 1'b1; m_up = !m_up;
          end else if (tk) begin m_step = 1'b1; m_step_up = m_up; end
          if (dl != m_prev_lvl) m_up = !dl;
`endif
        end
        M_STOPPED: begin
          if (e) m_mode = M_PAUSED;
          else if (!blocked) m_mode = M_RUNNING;
          m_up = !dl;
        end
        default: m_mode = M_PAUSED;
      endcase
      m_spd = nsp;
      m_prev_lvl = dl;
    end
    x.step      = m_step;
    x.step_up   = m_step_up;
    x.running   = (m_mode != M_PAUSED);
`ifdef COUNT_STEP_AUTO_REVERSE_EN
    x.limit_hit = m_pulse;
`else
    x.limit_hit = (m_mode == M_STOPPED);
`endif
    x.speed     = 2'(m_spd);
  endtask

  // Apply one cycle of inputs; the expectation is queued once the edge occurs.
  task automatic drive(input bit r, e, u, d, dl, mx, mn);
    exp_t x;
    rst = r; en_pulse = e; speed_up_pulse = u; speed_down_pulse = d;
    dir_level = dl; at_max = mx; at_min = mn;
    model_edge(r, e, u, d, dl, mx, mn, x);
    @(posedge clk);
    exp_q.push_back(x);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(0, 0, 0, 0, dir_level, at_max, at_min);
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        n_cmp++;
        if (step !== e.step || running !== e.running || limit_hit !== e.limit_hit ||
            speed !== e.speed || (e.step && step_up !== e.step_up)) begin
          n_bad++;
          $display("FAIL status @%0d: got step=%b up=%b run=%b lim=%b spd=%0d, want step=%b up=%b run=%b lim=%b spd=%0d",
                   cyc, step, step_up, running, limit_hit, speed,
                   e.step, e.step_up, e.running, e.limit_hit, e.speed);
        end
      end
    end
  end

  initial begin
    bit e, u, d, dl, mx, mn, r;
    int unsigned guard;
    // Reset, then run up at SLOW: steps 17/33/49 cycles after en_pulse.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (step !== 1'b0 || step_up !== 1'b1 || running !== 1'b0 ||
        limit_hit !== 1'b0 || speed !== 2'b00) begin
      n_bad++;
      $display("FAIL reset: step=%b up=%b run=%b lim=%b spd=%0d",
               step, step_up, running, limit_hit, speed);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(55);
    // Speed up twice (to FAST), then a saturating third request.
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(7);
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(6);
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(12);
    // Upper limit reached while counting up, then released by flipping direction.
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(10);
    drive(0, 0, 0, 0, 1, 1, 0);
    idle(10);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(6);
    // Pause exactly on a terminal cycle, then resume.
    guard = 0;
    while (!(m_mode == M_RUNNING && m_el == m_period() - 1) && guard < 100) begin
      idle(1);
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_bad++;
      $display("FAIL timeout: terminal cycle not reached within %0d cycles", guard);
    end
    drive(0, 1, 0, 0, dir_level, 0, 0);
    idle(5);
    drive(0, 1, 0, 0, dir_level, 0, 0);
    idle(8);
    // Simultaneous speed requests cancel.
    drive(0, 0, 1, 1, dir_level, 0, 0);
    idle(8);
    // Randomized traffic.
    dl = dir_level; mx = 0; mn = 0;
    for (int unsigned i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 799) == 0);
      e  = ($urandom_range(0, 69) == 0);
      u  = ($urandom_range(0, 44) == 0);
      d  = ($urandom_range(0, 44) == 0);
      if ($urandom_range(0, 59) == 0) dl = !dl;
      if ($urandom_range(0, 49) == 0) mx = !mx;
      if ($urandom_range(0, 49) == 0) mn = !mn;
      drive(r, e, u, d, dl, mx, mn);
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_step_scheduler.md
Name: count_step_scheduler

Overview:
- Sequencing controller for the 2-digit BCD up/down counter datapath.
- Owns three things:
  - run/pause mode FSM
  - 3-level speed select
  - step-rate prescaler
- Emits single-cycle step strobes with a direction qualifier. The counter datapath increments or decrements only on those strobes.
- Boundary flags from the datapath stop stepping at 00/99.
- Replaces free-running per-speed dividers with one programmable prescaler in the system clock domain.

Parameters:
- BASE_TICKS, 8388608: clk cycles per step at FAST speed. NORMAL = 2x, SLOW = 4x.
- CNT_W, 25: prescaler width. Must hold 4*BASE_TICKS-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en_pulse  in  1  one-cycle run/pause toggle (already debounced + one-pulsed)
- speed_up_pulse  in  1  one-cycle speed increment request
- speed_down_pulse  in  1  one-cycle speed decrement request
- dir_level  in  1  debounced direction switch: 0 = up, 1 = down
- at_max  in  1  datapath value == 99
- at_min  in  1  datapath value == 00
- step  out  1  one-cycle step strobe to datapath
- step_up  out  1  direction qualifier; valid when step = 1 (1 = increment)
- running  out  1  FSM in RUN or LIMIT
- limit_hit  out  1  FSM in LIMIT
- speed  out  2  00 = SLOW, 01 = NORMAL, 10 = FAST; drives display digit

Behaviour:
- Reset values (registered on posedge clk with rst = 1):
  - state = PAUSE
  - speed = SLOW
  - prescaler = 0
  - dir_q = 1 (up)
  - step = 0, step_up = 1, running = 0, limit_hit = 0
- All outputs are registered.
- Speed:
  - speed_up_pulse saturates at FAST; speed_down_pulse saturates at SLOW.
  - Both pulses in the same cycle: no change.
  - Speed changes are accepted in every state.
  - Any actual speed change clears the prescaler to 0 on the next cycle.
- Period: P = BASE_TICKS << (2 - speed), i.e. 4B / 2B / B.
- Prescaler:
  - Counts only in RUN.
  - Holds its value in PAUSE. Resume continues the partial period.
  - On reaching P-1 it wraps to 0 and raises tick for that cycle.
- Direction:
  - dir_q <= ~dir_level every cycle in RUN and LIMIT.
  - dir_q is frozen in PAUSE.
- FSM states:
  - PAUSE: en_pulse -> RUN.
  - RUN:
    - en_pulse -> PAUSE. en_pulse has priority over a same-cycle tick; no step is issued.
    - On tick with (dir_q && at_max) or (!dir_q && at_min): go to LIMIT with no step.
    - Otherwise on tick: step = 1 next cycle, step_up = dir_q.
  - LIMIT:
    - Prescaler held at 0.
    - en_pulse -> PAUSE.
    - The limit condition clearing, via direction flip or datapath change -> RUN; the prescaler starts from 0.
- Step latency: step asserts exactly 1 cycle after the tick cycle.
- Timing: first step after entering RUN from reset occurs P+1 cycles after the en_pulse cycle.
- step is never high for two consecutive cycles when BASE_TICKS >= 2.
- rst mid-period: prescaler cleared, any pending step dropped.

Optional Feature:
- Macro: COUNT_STEP_AUTO_REVERSE_EN.
- Defined (ping-pong mode):
  - On a tick at the limit, the FSM stays in RUN. dir_q inverts and a step in the new direction is issued with the normal 1-cycle latency.
  - dir_q loads ~dir_level only on a dir_level edge, not every cycle.
  - LIMIT is unreachable; limit_hit pulses for 1 cycle per reversal.
- Undefined: behaviour exactly as above.

Decomposition:
- Shared package count_pkg holds:
  - speed encodings SPD_SLOW / SPD_NORMAL / SPD_FAST
  - FSM state encodings ST_PAUSE / ST_RUN / ST_LIMIT
- One natural sub-module: step_prescaler.
  - Inputs: clk, rst, enable, clear, speed.
  - Output: tick.
  - Holds the counter and the period compare.

Test Plan (BASE_TICKS = 4):
- rst, then en_pulse at cycle 0, dir_level = 0, speed = SLOW -> step at cycles 17, 33, 49; step_up = 1; running = 1.
- speed_up_pulse twice while RUN, then a third -> speed = 10 and saturates. Prescaler clears; next step is 5 cycles after the second change. Steps continue every 4 cycles.
- at_max = 1, dir_level = 0, RUN -> no step, limit_hit = 1 after the next tick. Set dir_level = 1 -> limit_hit = 0; first step_up = 0 step P+1 cycles later.
- en_pulse in the same cycle as a tick -> no step, running = 0; prescaler holds. Second en_pulse -> step after the remaining count.
- speed_up_pulse and speed_down_pulse in the same cycle -> speed unchanged, prescaler not cleared.
- With COUNT_STEP_AUTO_REVERSE_EN, at_max = 1 during an up tick -> step with step_up = 0 one cycle later; 1-cycle limit_hit; running stays 1.
